// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared between the CPU core and its instruction
// prefetch FIFO.
//   cpu_state_t    - four-state core cycle (FETCH/DECODE/EXECUTE/WRITEBACK)
//   CPU_BYTE_W     - width of the core's instruction/immediate byte bus
//   FIFO_DEPTH_DEF - default number of prefetch FIFO entries
//   ptr_w()        - pointer width needed to address a FIFO of given depth
package cpu_defs;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    DECODE    = 2'b01,
    EXECUTE   = 2'b10,
    WRITEBACK = 2'b11
  } cpu_state_t;

  localparam int CPU_BYTE_W     = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  // Pointer width for a power-of-two depth; never below 1 so that a
  // degenerate depth still yields a legal vector.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_fifo_mem.sv
// instr_fifo_mem: DEPTH x WIDTH storage for the instruction prefetch FIFO.
// One synchronous write port and one asynchronous (combinational) read port.
// Storage has no reset; validity of entries is tracked by the owner.
//   clk     - clock, writes on rising edge
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - read data, combinational from rd_addr
module instr_fifo_mem
  import cpu_defs::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = CPU_BYTE_W,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Fall-through read: the head byte is visible in the same cycle the
  // pointer points at it.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fifo.sv
// instr_fifo: instruction prefetch FIFO between a byte-pushing host and the
// CPU core's instruction/immediate byte input.
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   in_data   - host byte
//   in_valid  - host byte present
//   in_ready  - FIFO can accept (count != DEPTH)
//   out_data  - head byte, first-word fall-through, 0 when empty
//   out_valid - head byte present (count != 0)
//   pop       - core consumes the head byte
//   flush     - discard all entries (priority over push/pop)
//   stall     - pop requested with nothing to give
//   count     - occupancy
//   underflow - sticky, set on pop while empty, cleared only by reset
module instr_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = CPU_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             underflow_reg;
  logic [WIDTH-1:0] head_data;

  logic push_ok;
  logic pop_ok;
  logic wr_en;

  // Handshake flags depend only on registered occupancy; a pop in the same
  // cycle never opens a slot for a push when full.
  assign in_ready  = (count_reg != FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign push_ok   = in_valid & in_ready;
  assign pop_ok    = pop & out_valid;
  assign stall     = pop & ~out_valid;

  // Flush wins over a push in the same cycle, so the write is suppressed too.
  assign wr_en = push_ok & ~flush;

  instr_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_data)
  );

  // Stale storage must never leak out while empty.
  assign out_data  = out_valid ? head_data : '0;
  assign count     = count_reg;
  assign underflow = underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Underflow is independent of flush: a pop against an empty FIFO is a
  // core-side protocol event worth remembering regardless of discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
    end else if (stall) begin
      underflow_reg <= 1'b1;
    end
  end

endmodule
